display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Sequences the digit select lines and registered segment data, inserting a blanking interval at each digit change to suppress ghosting.
- Double-buffers the displayed value and accepts updates through a req/ack handshake at frame boundaries.
- Sits between the counter/datapath logic and the board display pins.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; legal range is 2 or more.
- BLANK_CYC, 500: blank cycles at the start of each slot; must satisfy 1 <= BLANK_CYC < CLK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- en  input  1  scan enable
- load_req  input  1  new display value is valid; hold high until load_ack
- load_data  input  16  four BCD digits; [3:0] is digit0 (rightmost), [15:12] is digit3
- load_dp  input  4  decimal-point enable per digit, active-high
- load_ack  output  1  one-cycle pulse; load_data and load_dp captured this cycle
- sel  output  4  digit select, active-low; 1110 selects digit0, 0111 selects digit3
- seg  output  8  {a,b,c,d,e,f,g,dp}, active-low
- frame_done  output  1  one-cycle pulse on the last cycle of the digit3 slot

Behaviour:
- Reset values: sel=1111, seg=1111_1111, load_ack=0, frame_done=0, shadow value=0, shadow dp=0, prescaler=0, digit index=0, state IDLE.
- States:
  - IDLE: outputs blank.
  - BLANK: sel=1111, seg=FF.
  - SHOW: sel selects the current digit; seg carries the encoded digit.
- Transitions:
  - IDLE to BLANK on en=1; scanning starts at digit0 with prescaler=0.
  - BLANK to SHOW when prescaler reaches BLANK_CYC-1.
  - SHOW to BLANK when prescaler reaches CLK_DIV-1. The prescaler wraps to 0 and the digit index advances 0→1→2→3→0.
  - One slot is CLK_DIV cycles: BLANK_CYC blank cycles, then CLK_DIV-BLANK_CYC show cycles. One frame is 4*CLK_DIV cycles.
- en=0 in any state: the next state is IDLE. Prescaler and digit index clear, outputs blank the next cycle, and no frame_done is issued for the aborted frame.
- sel, seg, load_ack and frame_done are flip-flop outputs. The value present in cycle k matches the state/phase of cycle k, so next values are computed from next-state.
- Segment encoding (bit7..bit1 = a..g; bit0 = dp, 1 = off):
  - 0: 0000_001
  - 1: 1001_111
  - 2: 0010_010
  - 3: 0000_110
  - 4: 1001_100
  - 5: 0100_100
  - 6: 0100_000
  - 7: 0001_111
  - 8: 0000_000
  - 9: 0000_100
  - A–F: 1111_111 (blank)
- dp: seg[0] = ~shadow_dp[idx] during SHOW. A non-BCD digit with dp set shows only the dp.
- Load handshake:
  - When en=1, capture occurs on the frame_done cycle if load_req=1. load_ack pulses in that same cycle and the new value shows from the next digit0 slot.
  - When en=0 (IDLE), capture occurs on the first cycle load_req=1 is seen, with load_ack in that cycle.
  - Any load_req that arrives mid-frame waits; at most one ack is issued per frame.
  - If load_req drops before ack, no capture occurs.
  - load_req held high across multiple frames produces one ack per frame, each capturing the current load_data.
- Simultaneous en falling edge and frame boundary: en=0 wins, so no frame_done and no capture from the en path. The IDLE capture rule applies from the next cycle.
- Reset mid-frame: immediate return to reset values; any pending request is dropped.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- With the macro defined: during SHOW, digit3, digit2 and digit1 display blank when that digit and all more-significant digits are 0 and the digit's dp is clear. digit0 is never blanked. Example: 0x0070 shows "  70".
- Without the macro: all digits display, including leading zeros.

Decomposition:
- Shared package: segment constants SEG_0..SEG_9, SEG_BLANK (8'hFF), the select codes SEL_D0..SEL_D3 and SEL_NONE, and the state enum (IDLE, BLANK, SHOW).
- Sub-module seg7_encode: purely combinational, BCD plus dp to 8-bit active-low segments. Instantiated once in display_scan_ctrl.

Test Plan (CLK_DIV=8, BLANK_CYC=2):
- Reset, then en=1 with load_data=0x1234 (captured while idle) → digit0 slot shows 2 cycles of sel=1111/seg=FF, then 6 cycles of sel=1110/seg=1001_1001. frame_done pulses at cycle 32 of the frame.
- load_req mid-frame with 0x9876 → load_ack coincides with frame_done. Next frame digit0 shows seg=0100_0001. The old value persists until the boundary.
- load_dp=0010, value 0x0005 → digit1 slot shows seg=0000_0010. With LEADING_ZERO_BLANK_EN: digit3 and digit2 are blank, digit1 shows "0." and digit0 shows 5. Without the macro, digit3 and digit2 show seg=0000_0011.
- en dropped on cycle 13 → sel=1111/seg=FF from cycle 14 and no frame_done. Re-enabling restarts at digit0 BLANK.
- rst asserted asynchronously mid-SHOW → outputs go to 1111/FF immediately without waiting for a clock edge. After release, the shadow value is 0.
- Digit value 0xA with dp clear → seg=FF throughout the slot.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller.
// Segment glyphs, digit select codes and FSM state codes.
package display_scan_ctrl_pkg;

  // {a,b,c,d,e,f,g,dp}, active-low, dp off
  localparam logic [7:0] SEG_0 = 8'b0000_0011;
  localparam logic [7:0] SEG_1 = 8'b1001_1111;
  localparam logic [7:0] SEG_2 = 8'b0010_0101;
  localparam logic [7:0] SEG_3 = 8'b0000_1101;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b0100_1001;
  localparam logic [7:0] SEG_6 = 8'b0100_0001;
  localparam logic [7:0] SEG_7 = 8'b0001_1111;
  localparam logic [7:0] SEG_8 = 8'b0000_0001;
  localparam logic [7:0] SEG_9 = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low digit selects
  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b0111;
  localparam logic [3:0] SEL_NONE = 4'b1111;

  // Scan FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  function automatic logic [3:0] sel_code(
    input logic [1:0] idx
  );
    logic [3:0] s;
    case (idx)
      2'd1: s = SEL_D1;
      2'd2: s = SEL_D2;
      2'd3: s = SEL_D3;
      default: s = SEL_D0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_encode.sv
// seg7_encode: BCD digit plus dp to active-low segments.
// Non-BCD digits render blank; dp still honoured.
module seg7_encode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  // Glyph lookup; glyph bit0 is always 1 (dp off)
  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  end

  assign seg = blank ? SEG_BLANK
                     : (glyph & {7'h7F, ~dp});

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit 7-seg scanner, blanking, double buffer.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros (digits 3..1).
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_req,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic        load_ack,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BL_LAST = PW'(BLANK_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   val_q;
  logic [3:0]    dp_q;

  logic          frame_d;
  logic          cap_frame;
  logic          cap_idle;
  logic          cap;

  logic [3:0]    digit;
  logic          dp_on;
  logic          lz_blank;
  logic [7:0]    seg_enc;
  logic [7:0]    seg_d;
  logic [3:0]    sel_d;

  // Next-state, prescaler and digit index
  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_IDLE;
      ps_d    = '0;
      idx_d   = '0;
    end else begin
      unique case (1'b1)
        state_q == ST_IDLE: begin
          state_d = ST_BLANK;
          ps_d    = '0;
          idx_d   = '0;
        end
        state_q == ST_BLANK: begin
          ps_d = ps_q + 1'b1;
          if (ps_q == BL_LAST)
            state_d = ST_SHOW;
        end
        state_q == ST_SHOW: begin
          if (ps_q == PS_LAST) begin
            state_d = ST_BLANK;
            ps_d    = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ps_d    = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Frame end and the two capture windows (frame end, or idle)
  assign frame_d = (state_d == ST_SHOW) &&
                   (idx_d == 2'd3) &&
                   (ps_d == PS_LAST);
  assign cap_frame = frame_d && load_req;
  assign cap_idle  = (state_q == ST_IDLE) &&
                     load_req && !load_ack;
  assign cap = cap_frame || cap_idle;

  // Select the digit and dp that the next cycle displays
  always_comb begin
    digit = val_q[3:0];
    dp_on = dp_q[0];
    case (idx_d)
      2'd1: begin
        digit = val_q[7:4];
        dp_on = dp_q[1];
      end
      2'd2: begin
        digit = val_q[11:8];
        dp_on = dp_q[2];
      end
      2'd3: begin
        digit = val_q[15:12];
        dp_on = dp_q[3];
      end
      default: begin
        digit = val_q[3:0];
        dp_on = dp_q[0];
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  assign z3 = (val_q[15:12] == 4'd0);
  assign z2 = z3 && (val_q[11:8] == 4'd0);
  assign z1 = z2 && (val_q[7:4] == 4'd0);

  // Blank a leading zero unless its dp is lit
  always_comb begin
    lz_blank = 1'b0;
    case (idx_d)
      2'd3: lz_blank = z3 && !dp_q[3];
      2'd2: lz_blank = z2 && !dp_q[2];
      2'd1: lz_blank = z1 && !dp_q[1];
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  seg7_encode u_enc (
    .digit (digit),
    .dp    (dp_on),
    .blank (lz_blank),
    .seg   (seg_enc)
  );

  assign seg_d = (state_d == ST_SHOW) ? seg_enc
                                      : SEG_BLANK;
  assign sel_d = (state_d == ST_SHOW) ? sel_code(idx_d)
                                      : SEL_NONE;

  // Scan FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ps_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      idx_q   <= idx_d;
    end
  end

  // Shadow display value, updated only on an acknowledged load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      dp_q  <= '0;
    end else if (cap) begin
      val_q <= load_data;
      dp_q  <= load_dp;
    end
  end

  // Registered pin outputs aligned with the cycle's state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= SEL_NONE;
      seg        <= SEG_BLANK;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_d;
      seg        <= seg_d;
      load_ack   <= cap;
      frame_done <= frame_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (CLK_DIV=8, BLANK_CYC=2).
// Expected glyphs are hand-derived from the segment table.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load_req = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic        load_ack;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ_EXP = 8'hFF;
`else
  localparam logic [7:0] LZ_EXP = 8'h03;
`endif

  display_scan_ctrl #(
    .CLK_DIV   (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_req   (load_req),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_ack   (load_ack),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    checks++;
    if (sel !== 4'hF) begin
      errors++;
      $display("FAIL reset_sel got %b want 1111", sel);
    end
    checks++;
    if (seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_seg got %h want ff", seg);
    end
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack got %b want 0", load_ack);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd got %b want 0", frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_load();
    load_data = 16'h1234;
    load_dp = 4'b0000;
    load_req = 1'b1;
    tick();
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack got %b want 1", load_ack);
    end
    load_req = 1'b0;
    tick();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_drop got %b want 0", load_ack);
    end
  endtask

  task automatic test_scan_frame();
    logic [7:0] tbl [4];
    logic [3:0] xsel;
    logic [7:0] xseg;
    tbl = '{8'h99, 8'h0D, 8'h25, 8'h9F};
    en = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick();
      xsel = (c % 8 < 2) ? 4'hF : ~(4'b0001 << (c / 8));
      xseg = (c % 8 < 2) ? 8'hFF : tbl[c / 8];
      checks++;
      if (sel !== xsel) begin
        errors++;
        $display("FAIL scan_sel c=%0d got %b want %b", c + 1, sel, xsel);
      end
      checks++;
      if (seg !== xseg) begin
        errors++;
        $display("FAIL scan_seg c=%0d got %h want %h", c + 1, seg, xseg);
      end
      checks++;
      if (frame_done !== (c == 31)) begin
        errors++;
        $display("FAIL scan_fd c=%0d got %b", c + 1, frame_done);
      end
    end
  endtask

  task automatic test_mid_frame_load();
    logic [7:0] tbl [4];
    logic [7:0] xseg;
    tbl = '{8'h99, 8'h0D, 8'h25, 8'h9F};
    for (int c = 0; c < 32; c++) begin
      if (c == 8) begin
        load_data = 16'h9876;
        load_req = 1'b1;
      end
      tick();
      xseg = (c % 8 < 2) ? 8'hFF : tbl[c / 8];
      checks++;
      if (seg !== xseg) begin
        errors++;
        $display("FAIL old_value c=%0d got %h want %h", c + 1, seg, xseg);
      end
      checks++;
      if (load_ack !== (c == 31)) begin
        errors++;
        $display("FAIL mid_ack c=%0d got %b", c + 1, load_ack);
      end
      checks++;
      if (frame_done !== (c == 31)) begin
        errors++;
        $display("FAIL mid_fd c=%0d got %b", c + 1, frame_done);
      end
    end
    load_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      xseg = (c < 2) ? 8'hFF : 8'h41;
      checks++;
      if (seg !== xseg) begin
        errors++;
        $display("FAIL new_d0 c=%0d got %h want %h", c + 1, seg, xseg);
      end
    end
  endtask

  task automatic test_dp_lzb();
    logic [7:0] tbl [4];
    logic [7:0] xseg;
    tbl = '{8'h49, 8'h02, LZ_EXP, LZ_EXP};
    load_data = 16'h0005;
    load_dp = 4'b0010;
    load_req = 1'b1;
    for (int c = 8; c < 32; c++) begin
      tick();
      checks++;
      if (load_ack !== (c == 31)) begin
        errors++;
        $display("FAIL dp_ack c=%0d got %b", c + 1, load_ack);
      end
    end
    load_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      tick();
      xseg = (c % 8 < 2) ? 8'hFF : tbl[c / 8];
      checks++;
      if (seg !== xseg) begin
        errors++;
        $display("FAIL dp_seg c=%0d got %h want %h", c + 1, seg, xseg);
      end
    end
  endtask

  task automatic test_en_drop();
    bit bad = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    checks++;
    if (sel !== 4'b1101) begin
      errors++;
      $display("FAIL pre_drop_sel got %b want 1101", sel);
    end
    en = 1'b0;
    tick();
    checks++;
    if (sel !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL drop_blank got %b/%h want 1111/ff", sel, seg);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (frame_done !== 1'b0 || sel !== 4'hF) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL drop_idle got fd/sel activity want none");
    end
    en = 1'b1;
    tick();
    checks++;
    if (sel !== 4'hF) begin
      errors++;
      $display("FAIL restart_blank got %b want 1111", sel);
    end
    tick();
    tick();
    checks++;
    if (sel !== 4'b1110 || seg !== 8'h49) begin
      errors++;
      $display("FAIL restart_d0 got %b/%h want 1110/49", sel, seg);
    end
  endtask

  task automatic test_async_rst();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sel !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL async_rst got %b/%h want 1111/ff", sel, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (sel !== 4'b1110 || seg !== 8'h03) begin
      errors++;
      $display("FAIL rst_shadow got %b/%h want 1110/03", sel, seg);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_non_bcd();
    logic [7:0] xseg;
    for (int k = 0; k < 2; k++) begin
      en = 1'b0;
      tick();
      load_data = 16'h000A;
      load_dp = (k == 0) ? 4'b0000 : 4'b0001;
      load_req = 1'b1;
      tick();
      checks++;
      if (load_ack !== 1'b1) begin
        errors++;
        $display("FAIL nbcd_ack k=%0d got %b want 1", k, load_ack);
      end
      load_req = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 8; c++) begin
        tick();
        xseg = (c < 2 || k == 0) ? 8'hFF : 8'hFE;
        checks++;
        if (seg !== xseg) begin
          errors++;
          $display("FAIL nbcd_seg k=%0d c=%0d got %h want %h", k, c + 1, seg, xseg);
        end
      end
      checks++;
      if (sel !== 4'b1110) begin
        errors++;
        $display("FAIL nbcd_sel k=%0d got %b want 1110", k, sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int first = 0;
    bit bad = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    load_data = 16'h1111;
    load_dp = 4'b0000;
    load_req = 1'b1;
    for (int c = 2; c <= 64; c++) begin
      tick();
      if (load_ack === 1'b1) begin
        acks++;
        if (frame_done !== 1'b1) bad = 1'b1;
        if (acks == 1) begin
          first = c;
          load_data = 16'h2222;
        end
      end
    end
    load_req = 1'b0;
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL b2b_acks got %0d want 2", acks);
    end
    checks++;
    if (first != 32) begin
      errors++;
      $display("FAIL b2b_first got %0d want 32", first);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_ack_fd got ack without frame_done");
    end
    tick();
    tick();
    tick();
    checks++;
    if (sel !== 4'b1110 || seg !== 8'h25) begin
      errors++;
      $display("FAIL b2b_value got %b/%h want 1110/25", sel, seg);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle_load();
    test_scan_frame();
    test_mid_frame_load();
    test_dp_lzb();
    test_en_drop();
    test_async_rst();
    test_non_bcd();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
